// File: rtl/snn_pkg.sv
// Shared types and constant helpers for the SNN layer datapath blocks.
package snn_pkg;

    typedef enum logic {IDLE, ACCUM} state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Clamps a sign-extended value into the signed range of an out_w-bit result.
    function automatic longint sat_clamp_value(input longint value, input int out_w);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (out_w - 1)) - 1;
        lo = -(longint'(1) <<< (out_w - 1));
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/sat_clamp.sv
// Signed saturating narrowing from IN_W to OUT_W bits with a clamp flag.
module sat_clamp
    import snn_pkg::*;
#(
    parameter int IN_W  = 14,
    parameter int OUT_W = 8
) (
    input  logic signed [IN_W-1:0]  value,
    output logic signed [OUT_W-1:0] result,
    output logic                    clamped
);

    longint wide;
    longint limited;

    always_comb begin
        wide    = longint'(value);
        limited = sat_clamp_value(wide, OUT_W);
        result  = OUT_W'(limited);
        clamped = (limited != wide);
    end

endmodule

// File: rtl/spike_current_accumulator.sv
// Time-multiplexed weighted spike summation, LANES weights per cycle, with a
// saturated signed result and a one-cycle valid pulse.
module spike_current_accumulator
    import snn_pkg::*;
#(
    parameter int M             = 24,
    parameter int WEIGHT_W      = 8,
    parameter int OUT_W         = 8,
    parameter int LANES         = 4,
    parameter int WEIGHT_SIGNED = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      clear,
    input  logic [M-1:0]              input_spikes,
    input  logic [M*WEIGHT_W-1:0]     weights,
    output logic                      busy,
    output logic                      current_valid,
    output logic signed [OUT_W-1:0]   input_current,
    output logic                      saturated
);

    localparam int N     = ceil_div(M, LANES);
    localparam int ACC_W = WEIGHT_W + clog2(M) + 1;
    localparam int IDX_W = (N > 1) ? clog2(N) : 1;
    localparam int CW    = LANES * WEIGHT_W;

    state_t                    state;
    logic [M-1:0]              spikes_q;
    logic [M*WEIGHT_W-1:0]     weights_q;
    logic signed [ACC_W-1:0]   acc;
    logic [IDX_W-1:0]          idx;

    logic [LANES-1:0]          chunk_spk;
    logic [CW-1:0]             chunk_w;
    logic signed [ACC_W-1:0]   chunk_sum;
    logic signed [ACC_W-1:0]   final_sum;
    logic signed [OUT_W-1:0]   clamp_result;
    logic                      clamp_flag;

    function automatic logic signed [ACC_W-1:0] extend(input logic [WEIGHT_W-1:0] w);
        logic fill;
        fill = (WEIGHT_SIGNED != 0) ? w[WEIGHT_W-1] : 1'b0;
        return {{(ACC_W-WEIGHT_W){fill}}, w};
    endfunction

    // Shifting the captured vectors down brings in zeros, so lanes past M in a
    // partial final chunk contribute nothing.
    always_comb begin
        chunk_spk = LANES'(spikes_q >> (idx * LANES));
        chunk_w   = CW'(weights_q >> (idx * CW));
        chunk_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            if (chunk_spk[l]) begin
                chunk_sum = chunk_sum + extend(chunk_w[l*WEIGHT_W +: WEIGHT_W]);
            end
        end
        final_sum = acc + chunk_sum;
    end

    sat_clamp #(
        .IN_W  (ACC_W),
        .OUT_W (OUT_W)
    ) u_sat_clamp (
        .value   (final_sum),
        .result  (clamp_result),
        .clamped (clamp_flag)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            spikes_q      <= '0;
            weights_q     <= '0;
            acc           <= '0;
            idx           <= '0;
            busy          <= 1'b0;
            current_valid <= 1'b0;
            input_current <= '0;
            saturated     <= 1'b0;
        end else begin
            current_valid <= 1'b0;
            if (clear) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            spikes_q  <= input_spikes;
                            weights_q <= weights;
                            acc       <= '0;
                            idx       <= '0;
                            busy      <= 1'b1;
                            state     <= ACCUM;
                        end
                    end
                    ACCUM: begin
                        if (idx == IDX_W'(N - 1)) begin
                            input_current <= clamp_result;
                            saturated     <= clamp_flag;
                            current_valid <= 1'b1;
                            busy          <= 1'b0;
                            state         <= IDLE;
                        end else begin
                            acc <= final_sum;
                            idx <= idx + IDX_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spike_current_accumulator.sv
// Directed self-checking bench for spike_current_accumulator over four configurations.
module tb_spike_current_accumulator;

    logic clk;
    logic reset_n;

    logic        start0, clear0, busy0, valid0, sat0;
    logic [23:0] spk0;
    logic [191:0] w0;
    logic signed [7:0] cur0;

    logic        start1, clear1, busy1, valid1, sat1;
    logic [23:0] spk1;
    logic [191:0] w1;
    logic signed [7:0] cur1;

    logic        start2, clear2, busy2, valid2, sat2;
    logic [9:0]  spk2;
    logic [79:0] w2;
    logic signed [7:0] cur2;

    logic        start3, clear3, busy3, valid3, sat3;
    logic [9:0]  spk3;
    logic [79:0] w3;
    logic signed [7:0] cur3;

    int curSel;
    logic       selBusy, selValid, selSat;
    logic [7:0] selCur;

    int checks;
    int errors;

    spike_current_accumulator dut0 (
        .clk(clk), .reset_n(reset_n), .start(start0), .clear(clear0),
        .input_spikes(spk0), .weights(w0), .busy(busy0),
        .current_valid(valid0), .input_current(cur0), .saturated(sat0)
    );

    spike_current_accumulator #(.WEIGHT_SIGNED(0)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .clear(clear1),
        .input_spikes(spk1), .weights(w1), .busy(busy1),
        .current_valid(valid1), .input_current(cur1), .saturated(sat1)
    );

    spike_current_accumulator #(.M(10), .LANES(4)) dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2), .clear(clear2),
        .input_spikes(spk2), .weights(w2), .busy(busy2),
        .current_valid(valid2), .input_current(cur2), .saturated(sat2)
    );

    spike_current_accumulator #(.M(10), .LANES(10)) dut3 (
        .clk(clk), .reset_n(reset_n), .start(start3), .clear(clear3),
        .input_spikes(spk3), .weights(w3), .busy(busy3),
        .current_valid(valid3), .input_current(cur3), .saturated(sat3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        selBusy  = busy0;
        selValid = valid0;
        selSat   = sat0;
        selCur   = cur0;
        case (curSel)
            1: begin selBusy = busy1; selValid = valid1; selSat = sat1; selCur = cur1; end
            2: begin selBusy = busy2; selValid = valid2; selSat = sat2; selCur = cur2; end
            3: begin selBusy = busy3; selValid = valid3; selSat = sat3; selCur = cur3; end
            default: ;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int sel, input logic value);
        curSel = sel;
        case (sel)
            0: start0 = value;
            1: start1 = value;
            2: start2 = value;
            default: start3 = value;
        endcase
    endtask

    // Bounded wait for the selected instance's valid, counting busy cycles.
    task automatic waitValid(output bit seen, output int busyCnt);
        seen    = 1'b0;
        busyCnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (selValid) begin
                seen = 1'b1;
                break;
            end
            if (selBusy) busyCnt++;
            tick();
        end
    endtask

    task automatic runTxn(input int sel, input int expBusy, input logic [7:0] expCur,
                          input logic expSat, input string tag);
        bit seen;
        int busyCnt;
        applyStimulus(sel, 1'b1);
        tick();
        applyStimulus(sel, 1'b0);
        waitValid(seen, busyCnt);
        checkOutput({tag, "_valid"}, 32'(seen), 32'd1);
        checkOutput({tag, "_busycycles"}, 32'(busyCnt), 32'(expBusy));
        checkOutput({tag, "_current"}, 32'(selCur), 32'(expCur));
        checkOutput({tag, "_saturated"}, 32'(selSat), 32'(expSat));
        tick();
        checkOutput({tag, "_pulse"}, 32'(selValid), 32'd0);
    endtask

    task automatic setSparse0(input logic [7:0] w23);
        spk0 = '0;
        spk0[0] = 1'b1; spk0[5] = 1'b1; spk0[23] = 1'b1;
        for (int i = 0; i < 24; i++) w0[i*8 +: 8] = 8'h55;
        w0[0*8 +: 8]  = 8'd10;
        w0[5*8 +: 8]  = 8'd20;
        w0[23*8 +: 8] = w23;
    endtask

    task automatic setUniform0(input logic [23:0] spikes, input logic [7:0] w);
        spk0 = spikes;
        for (int i = 0; i < 24; i++) w0[i*8 +: 8] = w;
    endtask

    initial begin
        bit seen;
        int busyCnt;
        int validCnt;

        checks  = 0;
        errors  = 0;
        curSel  = 0;
        reset_n = 1'b0;
        start0 = 0; clear0 = 0; spk0 = '0; w0 = '0;
        start1 = 0; clear1 = 0; spk1 = '1; w1 = '1;
        start2 = 0; clear2 = 0; spk2 = '1; w2 = '0;
        start3 = 0; clear3 = 0; spk3 = '1; w3 = '0;
        for (int i = 0; i < 10; i++) begin
            w2[i*8 +: 8] = 8'(i + 1);
            w3[i*8 +: 8] = 8'(i + 1);
        end

        tick();
        tick();
        checkOutput("reset_busy", 32'(busy0), 32'd0);
        checkOutput("reset_valid", 32'(valid0), 32'd0);
        checkOutput("reset_current", 32'(cur0), 32'd0);
        checkOutput("reset_saturated", 32'(sat0), 32'd0);
        reset_n = 1'b1;
        tick();

        setUniform0(24'h000000, 8'h7F);
        runTxn(0, 6, 8'd0, 1'b0, "zero_spikes");

        setSparse0(8'd30);
        runTxn(0, 6, 8'd60, 1'b0, "sparse_pos");

        setSparse0(8'hE2);
        runTxn(0, 6, 8'd0, 1'b0, "sparse_neg");

        setUniform0(24'hFFFFFF, 8'h7F);
        runTxn(0, 6, 8'h7F, 1'b1, "sat_high");

        setUniform0(24'hFFFFFF, 8'h80);
        runTxn(0, 6, 8'h80, 1'b1, "sat_low");

        // A second start while busy must not spawn another result.
        setSparse0(8'd30);
        applyStimulus(0, 1'b1);
        tick();
        applyStimulus(0, 1'b0);
        tick();
        applyStimulus(0, 1'b1);
        tick();
        applyStimulus(0, 1'b0);
        validCnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (valid0) validCnt++;
            tick();
        end
        checkOutput("busy_start_validcount", 32'(validCnt), 32'd1);
        checkOutput("busy_start_current", 32'(cur0), 32'd60);

        // Start held through the valid cycle launches the next sum immediately.
        setSparse0(8'd30);
        applyStimulus(0, 1'b1);
        tick();
        waitValid(seen, busyCnt);
        checkOutput("b2b_first_valid", 32'(seen), 32'd1);
        checkOutput("b2b_first_current", 32'(cur0), 32'd60);
        w0[23*8 +: 8] = 8'hE2;
        tick();
        applyStimulus(0, 1'b0);
        checkOutput("b2b_nobubble", 32'(busy0), 32'd1);
        waitValid(seen, busyCnt);
        checkOutput("b2b_second_valid", 32'(seen), 32'd1);
        checkOutput("b2b_second_busy", 32'(busyCnt), 32'd6);
        checkOutput("b2b_second_current", 32'(cur0), 32'd0);
        tick();

        setSparse0(8'd30);
        applyStimulus(0, 1'b1);
        tick();
        applyStimulus(0, 1'b0);
        tick();
        tick();
        setUniform0(24'hFFFFFF, 8'h7F);
        waitValid(seen, busyCnt);
        checkOutput("midchange_valid", 32'(seen), 32'd1);
        checkOutput("midchange_current", 32'(cur0), 32'd60);
        checkOutput("midchange_saturated", 32'(sat0), 32'd0);
        tick();

        setUniform0(24'hFFFFFF, 8'h7F);
        applyStimulus(0, 1'b1);
        tick();
        applyStimulus(0, 1'b0);
        tick();
        clear0 = 1'b1;
        tick();
        clear0 = 1'b0;
        checkOutput("clear_busy", 32'(busy0), 32'd0);
        validCnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (valid0) validCnt++;
            tick();
        end
        checkOutput("clear_novalid", 32'(validCnt), 32'd0);
        checkOutput("clear_current_kept", 32'(cur0), 32'd60);
        checkOutput("clear_sat_kept", 32'(sat0), 32'd0);

        // Asynchronous reset mid-accumulation, checked before the next edge.
        setUniform0(24'hFFFFFF, 8'h7F);
        applyStimulus(0, 1'b1);
        tick();
        applyStimulus(0, 1'b0);
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_busy", 32'(busy0), 32'd0);
        checkOutput("midreset_valid", 32'(valid0), 32'd0);
        checkOutput("midreset_current", 32'(cur0), 32'd0);
        checkOutput("midreset_saturated", 32'(sat0), 32'd0);
        #2;
        reset_n = 1'b1;
        tick();
        validCnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (valid0) validCnt++;
            tick();
        end
        checkOutput("midreset_novalid", 32'(validCnt), 32'd0);

        runTxn(1, 6, 8'h7F, 1'b1, "unsigned_sat");
        runTxn(2, 3, 8'd55, 1'b0, "m10_l4");
        runTxn(3, 1, 8'd55, 1'b0, "m10_l10");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
